// File: rtl/grf_writeback.sv
// -----------------------------------------------------------------------------
// grf_writeback
//   Write-back end of the CPU register datapath. It contains three parts:
//   - the MEM/WB pipeline register,
//   - the write-data source select,
//   - the general register file (GRF), with NREG entries of DW bits.
//   The two read ports are combinational. Each one bypasses the WB-stage write
//   so that decode sees a value in the same cycle it is being written.
//   The registered WB write bus is exported so hazard and forwarding logic can
//   use it as a forward source.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous active-low reset (0 = reset)
//   en                   MEM/WB load enable (0 = stall, hold contents)
//   flush                load a bubble into MEM/WB on the next edge
//   m_regwe, m_wa        MEM-stage write request and destination register
//   m_wdsel              write-data source: 0 ALU, 1 memory, 2 PC+8, 3 reserved (zero)
//   m_alu, m_mem, m_pc8  MEM-stage candidate write data
//   m_pc                 MEM-stage PC, carried along for tracing
//   ra1/rd1, ra2/rd2     read ports feeding the decode-stage operand muxes
//   w_we, w_wa, w_wd     WB-stage effective write enable, destination and data
//   w_pc                 WB-stage PC
// -----------------------------------------------------------------------------
module grf_writeback #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          m_regwe,
    input  logic [AW-1:0] m_wa,
    input  logic [1:0]    m_wdsel,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_mem,
    input  logic [DW-1:0] m_pc8,
    input  logic [DW-1:0] m_pc,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          w_we,
    output logic [AW-1:0] w_wa,
    output logic [DW-1:0] w_wd,
    output logic [DW-1:0] w_pc
);

    // Write-data source select. The reserved encoding yields zero, so an
    // undefined selection never writes stale data.
    function automatic logic [DW-1:0] wd_select(
        input logic [1:0]    sel,
        input logic [DW-1:0] alu,
        input logic [DW-1:0] mem,
        input logic [DW-1:0] pc8
    );
        logic [DW-1:0] res;
        case (sel)
            2'd0:    res = alu;
            2'd1:    res = mem;
            2'd2:    res = pc8;
            default: res = {DW{1'b0}};
        endcase
        return res;
    endfunction

    logic          w_we_r;
    logic [AW-1:0] w_wa_r;
    logic [DW-1:0] w_wd_r;
    logic [DW-1:0] w_pc_r;
    logic [DW-1:0] grf_r [NREG];
    logic [DW-1:0] rd1_s;
    logic [DW-1:0] rd2_s;

    // MEM/WB pipeline register. Priority order is reset, then flush, then
    // load, then hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_we_r <= 1'b0;
            w_wa_r <= {AW{1'b0}};
            w_wd_r <= {DW{1'b0}};
            w_pc_r <= {DW{1'b0}};
        end else if (flush) begin
            w_we_r <= 1'b0;
            w_wa_r <= {AW{1'b0}};
            w_wd_r <= {DW{1'b0}};
            w_pc_r <= {DW{1'b0}};
        end else if (en) begin
            // Gating the enable on a non-zero destination keeps $0 constant
            // and keeps a $0 write from showing up on the bypass path.
            w_we_r <= m_regwe && (m_wa != {AW{1'b0}});
            w_wa_r <= m_wa;
            w_wd_r <= wd_select(m_wdsel, m_alu, m_mem, m_pc8);
            w_pc_r <= m_pc;
        end else begin
            w_we_r <= w_we_r;
            w_wa_r <= w_wa_r;
            w_wd_r <= w_wd_r;
            w_pc_r <= w_pc_r;
        end
    end

    // Register file write. This ignores en and flush because the instruction
    // already in WB must retire. A stall re-presents the same write, and
    // writing the same value twice is harmless. A reset edge discards the
    // pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                grf_r[i] <= {DW{1'b0}};
            end
        end else if (w_we_r) begin
            grf_r[w_wa_r] <= w_wd_r;
        end else begin
            grf_r[w_wa_r] <= grf_r[w_wa_r];
        end
    end

    // Read port 1: $0 reads zero, then the same-cycle WB write, then storage.
    always_comb begin
        rd1_s = {DW{1'b0}};
        if (ra1 == {AW{1'b0}}) begin
            rd1_s = {DW{1'b0}};
        end else if (w_we_r && (w_wa_r == ra1)) begin
            rd1_s = w_wd_r;
        end else begin
            rd1_s = grf_r[ra1];
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        rd2_s = {DW{1'b0}};
        if (ra2 == {AW{1'b0}}) begin
            rd2_s = {DW{1'b0}};
        end else if (w_we_r && (w_wa_r == ra2)) begin
            rd2_s = w_wd_r;
        end else begin
            rd2_s = grf_r[ra2];
        end
    end

    assign rd1  = rd1_s;
    assign rd2  = rd2_s;
    assign w_we = w_we_r;
    assign w_wa = w_wa_r;
    assign w_wd = w_wd_r;
    assign w_pc = w_pc_r;

endmodule
